// File: rtl/posit_pkg.sv
// Shared posit defaults, field-width derivations and the unpacked operand record.
package posit_pkg;

   localparam int unsigned POSIT_N  = 32;
   localparam int unsigned POSIT_ES = 2;

   function automatic int unsigned posit_sw(input int unsigned n, input int unsigned es);
      return $clog2(n) + es + 1;
   endfunction

   function automatic int unsigned posit_fw(input int unsigned n, input int unsigned es);
      return n - es - 2;
   endfunction

   localparam int unsigned POSIT_SW = posit_sw(POSIT_N, POSIT_ES);
   localparam int unsigned POSIT_FW = posit_fw(POSIT_N, POSIT_ES);

   typedef struct packed {
      logic                       sign;
      logic signed [POSIT_SW-1:0] scale;
      logic [POSIT_FW-1:0]        frac;
      logic                       zero;
      logic                       inf;
   } posit_unpacked_t;

endpackage

// File: rtl/posit_lzc.sv
// Leading-run counter: length of the run of pol_i bits from the MSB of bits_i.
module posit_lzc #(
   parameter  int unsigned W  = 31,
   localparam int unsigned CW = $clog2(W + 1)
) (
   input  logic [W-1:0]  bits_i,
   input  logic          pol_i,
   output logic [CW-1:0] count_o,
   output logic          all_same_o
);

   logic found;

   always_comb begin
      count_o = CW'(W);
      found   = 1'b0;
      for (int unsigned i = 0; i < W; i++) begin
         if (!found && (bits_i[W-1-i] != pol_i)) begin
            count_o = CW'(i);
            found   = 1'b1;
         end
      end
   end

   assign all_same_o = (count_o == CW'(W));

endmodule

// File: rtl/posit_decode_stream.sv
// 3-stage streaming posit decoder (sign/abs, regime, exponent+fraction).
// Optional POSIT_DECODE_SKID_EN: registered in_ready with a 1-entry skid buffer ahead of S1.
module posit_decode_stream
   import posit_pkg::*;
#(
   parameter  int unsigned N  = POSIT_N,
   parameter  int unsigned ES = POSIT_ES,
   localparam int unsigned SW = posit_sw(N, ES),
   localparam int unsigned FW = posit_fw(N, ES)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N-1:0]         in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_sign,
   output logic signed [SW-1:0] out_scale,
   output logic [FW-1:0]        out_frac,
   output logic                 out_zero,
   output logic                 out_inf
);

   localparam int unsigned CW = $clog2(N);
   localparam int unsigned RW = N - 3;
   localparam logic signed [SW-1:0] K_ONE = SW'(1);

   logic adv;
   logic src_valid;
   logic [N-1:0] src_word;

   logic out_v_q;
   posit_unpacked_t out_q, out_d;

   assign adv = !out_v_q || out_ready;

`ifdef POSIT_DECODE_SKID_EN
   logic skid_full_q, skid_full_d;
   logic [N-1:0] skid_word_q, skid_word_d;

   // The skid only fills when a word is accepted in a cycle the pipe cannot advance.
   always_comb begin
      skid_full_d = skid_full_q;
      skid_word_d = skid_word_q;
      if (adv) begin
         skid_full_d = 1'b0;
      end else if (!skid_full_q && in_valid) begin
         skid_full_d = 1'b1;
         skid_word_d = in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         skid_full_q <= 1'b0;
         skid_word_q <= '0;
      end else begin
         skid_full_q <= skid_full_d;
         skid_word_q <= skid_word_d;
      end
   end

   assign in_ready  = !skid_full_q;
   assign src_valid = skid_full_q || in_valid;
   assign src_word  = skid_full_q ? skid_word_q : in_data;
`else
   assign in_ready  = adv;
   assign src_valid = in_valid;
   assign src_word  = in_data;
`endif

   logic         s1_v_q, s1_sign_q, s1_zero_q, s1_nar_q;
   logic [N-2:0] s1_body_q;
   logic [N-1:0] src_abs;
   logic         s1_sign_d, s1_zero_d, s1_nar_d;

   always_comb begin
      s1_sign_d = src_word[N-1];
      src_abs   = s1_sign_d ? (-src_word) : src_word;
      s1_zero_d = (src_word == '0);
      s1_nar_d  = (src_word == {1'b1, {(N-1){1'b0}}});
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_v_q    <= 1'b0;
         s1_sign_q <= 1'b0;
         s1_zero_q <= 1'b0;
         s1_nar_q  <= 1'b0;
         s1_body_q <= '0;
      end else if (adv) begin
         s1_v_q    <= src_valid;
         s1_sign_q <= s1_sign_d;
         s1_zero_q <= s1_zero_d;
         s1_nar_q  <= s1_nar_d;
         s1_body_q <= src_abs[N-2:0];
      end
   end

   logic                 run_pol, run_all;
   logic [CW-1:0]        run_len;
   logic [CW:0]          shamt;
   logic [N-2:0]         shifted;
   logic signed [SW-1:0] run_s, s2_k_d;
   logic [RW-1:0]        s2_rem_d;

   logic                 s2_v_q, s2_sign_q, s2_zero_q, s2_nar_q;
   logic signed [SW-1:0] s2_k_q;
   logic [RW-1:0]        s2_rem_q;

   assign run_pol = s1_body_q[N-2];

   posit_lzc #(.W(N - 1)) u_lzc (
      .bits_i     (s1_body_q),
      .pol_i      (run_pol),
      .count_o    (run_len),
      .all_same_o (run_all)
   );

   // Skip the run plus its terminator; a run filling the body leaves nothing behind.
   always_comb begin
      run_s    = $signed(SW'(run_len));
      s2_k_d   = run_pol ? (run_s - K_ONE) : (-run_s);
      shamt    = {1'b0, run_len} + (CW+1)'(1);
      shifted  = s1_body_q << shamt;
      s2_rem_d = run_all ? '0 : shifted[N-2:2];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s2_v_q    <= 1'b0;
         s2_sign_q <= 1'b0;
         s2_zero_q <= 1'b0;
         s2_nar_q  <= 1'b0;
         s2_k_q    <= '0;
         s2_rem_q  <= '0;
      end else if (adv) begin
         s2_v_q    <= s1_v_q;
         s2_sign_q <= s1_sign_q;
         s2_zero_q <= s1_zero_q;
         s2_nar_q  <= s1_nar_q;
         s2_k_q    <= s2_k_d;
         s2_rem_q  <= s2_rem_d;
      end
   end

   logic [ES-1:0] exp_bits;

   always_comb begin
      exp_bits    = s2_rem_q[RW-1 -: ES];
      out_d.sign  = s2_sign_q;
      out_d.scale = (s2_k_q <<< ES) + $signed({{(SW-ES){1'b0}}, exp_bits});
      out_d.frac  = {1'b1, s2_rem_q[RW-ES-1:0]};
      out_d.zero  = 1'b0;
      out_d.inf   = 1'b0;
      if (s2_zero_q) begin
         out_d.sign  = 1'b0;
         out_d.scale = '0;
         out_d.frac  = '0;
         out_d.zero  = 1'b1;
      end else if (s2_nar_q) begin
         out_d.sign  = 1'b1;
         out_d.scale = '0;
         out_d.frac  = '0;
         out_d.inf   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_v_q <= 1'b0;
         out_q   <= '0;
      end else if (adv) begin
         out_v_q <= s2_v_q;
         out_q   <= out_d;
      end
   end

   logic unused_bits;
   assign unused_bits = ^{src_abs[N-1], shifted[1:0]};

   assign out_valid = out_v_q;
   assign out_sign  = out_q.sign;
   assign out_scale = out_q.scale;
   assign out_frac  = out_q.frac;
   assign out_zero  = out_q.zero;
   assign out_inf   = out_q.inf;

endmodule
